uart_receiver: RTL

Serial-to-parallel UART receiver; the receive-side counterpart of the team's uart_transmitter.
- Oversamples the asynchronous rx line with an internal tick divider derived from clk.
- Validates the start bit at mid-bit and shifts in 8 data bits, LSB first.
- Checks the stop bit and presents each received byte with a single-cycle valid strobe.
- Sits beside uart_transmitter inside the UART top; shares the system clk and reset.

---
 rtl/uart_receiver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8-bit UART receiver: 2-flop synchronizer, oversampling tick divider, mid-bit sampling FSM.
// Optional even-parity bit enabled with `define UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       data_valid,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);
    localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [OS_W-1:0]  sample_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       dataout_q;
    logic             data_valid_q, framing_error_q;
    logic             tick, fall, half_pt, full_pt;

    assign tick    = (div_cnt_q == DIV_LAST);
    assign fall    = rx_prev_q && !rx_s_q;
    assign half_pt = tick && (sample_cnt_q == HALF_LAST);
    assign full_pt = tick && (sample_cnt_q == OS_LAST);

`ifdef UART_RX_PARITY_EN
    logic parity_bit_q, parity_error_q;
    logic parity_ok;
    // Even parity: data bits and parity bit together must XOR to zero.
    assign parity_ok = ~^{shift_q, parity_bit_q};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (fall) state_d = StStart;
            StStart: if (half_pt) state_d = rx_s_q ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
            StData:   if (full_pt && bit_cnt_q == 3'd7) state_d = StParity;
            StParity: if (full_pt) state_d = StStop;
`else
            StData:  if (full_pt && bit_cnt_q == 3'd7) state_d = StStop;
`endif
            StStop:  if (full_pt) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q       <= 1'b1;
            rx_s_q          <= 1'b1;
            rx_prev_q       <= 1'b1;
            div_cnt_q       <= '0;
            sample_cnt_q    <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            dataout_q       <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q       <= rx;
            rx_s_q          <= rx_meta_q;
            rx_prev_q       <= rx_s_q;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q  <= 1'b0;
`endif
            // Restart the divider on the start edge so ticks line up with bit boundaries.
            if ((state_q == StIdle && fall) || tick) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end

            if (state_q == StIdle || (state_q == StStart && half_pt) || full_pt) begin
                sample_cnt_q <= '0;
            end else if (tick) begin
                sample_cnt_q <= sample_cnt_q + OS_W'(1);
            end

            if (state_q == StIdle) begin
                bit_cnt_q <= '0;
            end else if (state_q == StData && full_pt) begin
                shift_q[bit_cnt_q] <= rx_s_q;
                bit_cnt_q          <= bit_cnt_q + 3'd1;
            end

`ifdef UART_RX_PARITY_EN
            if (state_q == StParity && full_pt) begin
                parity_bit_q <= rx_s_q;
            end
`endif

            if (state_q == StStop && full_pt) begin
                if (!rx_s_q) begin
                    framing_error_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                end else if (!parity_ok) begin
                    parity_error_q <= 1'b1;
`endif
                end else begin
                    dataout_q    <= shift_q;
                    data_valid_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy          = (state_q != StIdle);
        dataout       = dataout_q;
        data_valid    = data_valid_q;
        framing_error = framing_error_q;
`ifdef UART_RX_PARITY_EN
        parity_error  = parity_error_q;
`else
        parity_error  = 1'b0;
`endif
    end
endmodule
